// File: rtl/pool2d_engine.sv
// pool2d_engine
//   Reads a CHW feature map from the conv-output BRAM one pooling window at a
//   time, reduces each window by max or average, and writes one result per
//   window to the pool BRAM. Reads are pipelined at one per cycle; returning
//   data is matched to its window by a valid/first tag pipeline as deep as the
//   BRAM read latency.
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   start, mode : one-cycle start request (IDLE only); mode 0 = max, 1 = average
//   conv_addr, conv_en, conv_q : conv BRAM read port (data BRAM_LAT cycles later)
//   pool_addr, pool_en, pool_we, pool_d : pool BRAM write port
//   busy, done  : busy from accepted start until done; done is a one-cycle pulse
module pool2d_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_SIZE    = 28,
  parameter int POOL       = 2,
  parameter int STRIDE     = 2,
  parameter int BRAM_LAT   = 2,
  localparam int OUT_SIZE  = (STRIDE >= 1 && POOL <= IN_SIZE) ? (IN_SIZE - POOL) / STRIDE + 1 : 1,
  localparam int CONV_N    = CHANNELS * IN_SIZE * IN_SIZE,
  localparam int POOL_N    = CHANNELS * OUT_SIZE * OUT_SIZE,
  localparam int CONV_AW   = (CONV_N > 1) ? $clog2(CONV_N) : 1,
  localparam int POOL_AW   = (POOL_N > 1) ? $clog2(POOL_N) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mode,
  output logic [CONV_AW-1:0]           conv_addr,
  output logic                         conv_en,
  input  logic signed [DATA_WIDTH-1:0] conv_q,
  output logic [POOL_AW-1:0]           pool_addr,
  output logic                         pool_en,
  output logic                         pool_we,
  output logic signed [DATA_WIDTH-1:0] pool_d,
  output logic                         busy,
  output logic                         done
);

  localparam int KK    = POOL * POOL;
  localparam int SH    = $clog2(KK);
  localparam int ACC_W = DATA_WIDTH + SH;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OUT_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int K_W   = (POOL > 1) ? $clog2(POOL) : 1;

  localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [OUT_W-1:0]   OUT_LAST = OUT_W'(OUT_SIZE - 1);
  localparam logic [K_W-1:0]     K_LAST   = K_W'(POOL - 1);
  localparam logic [2:0]         LAT_LAST = 3'(BRAM_LAT - 1);
  localparam logic [CONV_AW-1:0] PLANE    = CONV_AW'(IN_SIZE * IN_SIZE);
  localparam logic [CONV_AW-1:0] ROW      = CONV_AW'(IN_SIZE);
  localparam logic [CONV_AW-1:0] STEP     = CONV_AW'(STRIDE);

  if (POOL < 1 || (POOL & (POOL - 1)) != 0) begin : g_chk_pool
    $error("pool2d_engine: POOL must be a power of two");
  end
  if (STRIDE < 1 || POOL > IN_SIZE) begin : g_chk_geom
    $error("pool2d_engine: need STRIDE >= 1 and POOL <= IN_SIZE");
  end
  if (BRAM_LAT < 1 || BRAM_LAT > 4) begin : g_chk_lat
    $error("pool2d_engine: BRAM_LAT must be in 1..4");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FINISH} state_t;

  state_t             state;
  logic               avg_mode;
  logic [CH_W-1:0]    ch;
  logic [OUT_W-1:0]   r, q;
  logic [K_W-1:0]     dy, dx;
  logic [POOL_AW-1:0] ptr;
  logic [2:0]         drain_cnt;
  logic               last_win;
  logic               issue;

  logic [BRAM_LAT-1:0]     vld_p;
  logic [BRAM_LAT-1:0]     first_p;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] samp;

  // Signed max of the running value and a new sample.
  function automatic logic signed [ACC_W-1:0] sel_max(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  // Window sum to mean: arithmetic shift floors toward -inf, then narrow.
  function automatic logic signed [DATA_WIDTH-1:0] avg_floor(input logic signed [ACC_W-1:0] a);
    return DATA_WIDTH'(a >>> SH);
  endfunction

  assign issue    = (state == ISSUE);
  assign last_win = (ch == CH_LAST) && (r == OUT_LAST) && (q == OUT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      avg_mode  <= 1'b0;
      ch        <= '0;
      r         <= '0;
      q         <= '0;
      dy        <= '0;
      dx        <= '0;
      ptr       <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            avg_mode <= mode;
            ch       <= '0;
            r        <= '0;
            q        <= '0;
            dy       <= '0;
            dx       <= '0;
            ptr      <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (dx == K_LAST) begin
            dx <= '0;
            if (dy == K_LAST) begin
              dy        <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              dy <= dy + K_W'(1);
            end
          end else begin
            dx <= dx + K_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAT_LAST) state <= WRITE;
          else drain_cnt <= drain_cnt + 3'd1;
        end
        WRITE: begin
          ptr <= ptr + POOL_AW'(1);
          if (last_win) begin
            state <= FINISH;
          end else begin
            state <= ISSUE;
            if (q == OUT_LAST) begin
              q <= '0;
              if (r == OUT_LAST) begin
                r  <= '0;
                ch <= ch + CH_W'(1);
              end else begin
                r <= r + OUT_W'(1);
              end
            end else begin
              q <= q + OUT_W'(1);
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read issue stage: address is a pure function of the registered indices.
  always_comb begin
    conv_en   = issue;
    conv_addr = '0;
    if (issue)
      conv_addr = CONV_AW'(ch) * PLANE
                + (CONV_AW'(r) * STEP + CONV_AW'(dy)) * ROW
                + CONV_AW'(q) * STEP + CONV_AW'(dx);
  end

  // BRAM latency stages: tag each read so its data is recognised on return.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p   <= '0;
      first_p <= '0;
    end else begin
      vld_p[0]   <= issue;
      first_p[0] <= issue && (dy == '0) && (dx == '0);
      for (int i = 1; i < BRAM_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
      end
    end
  end

  // Sign-extending cast: conv_q is signed, so the widening replicates its MSB.
  assign samp = ACC_W'(conv_q);

  // Return stage: first read of a window loads, later reads combine.
  always_ff @(posedge clk) begin
    if (vld_p[BRAM_LAT-1]) begin
      if (first_p[BRAM_LAT-1]) acc <= samp;
      else if (avg_mode)       acc <= acc + samp;
      else                     acc <= sel_max(acc, samp);
    end
  end

  // Write stage: outputs are decoded from the state register only.
  always_comb begin
    pool_en   = (state == WRITE);
    pool_we   = (state == WRITE);
    pool_addr = '0;
    pool_d    = '0;
    if (state == WRITE) begin
      pool_addr = ptr;
      pool_d    = avg_mode ? avg_floor(acc) : DATA_WIDTH'(acc);
    end
    busy = (state == ISSUE) || (state == DRAIN) || (state == WRITE);
    done = (state == FINISH);
  end

endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench for pool2d_engine: four instances cover single/multi channel,
// overlapping windows and BRAM latencies 1, 2 and 3, each fed by a latency-
// matched model BRAM reading a shared memory image.
module tb_pool2d_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic mode  = 1'b0;
  int   sel   = 0;

  logic signed [15:0] mem [32];

  int n_pass = 0;
  int n_chk  = 0;
  int exp_v [8];
  int caq [$];

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // A: CH=1 IN=4 K=2 S=2 LAT=2
  logic [3:0] a_caddr; logic a_cen; logic signed [15:0] a_q, a_pd;
  logic [1:0] a_paddr; logic a_pen, a_pwe, a_busy, a_done;
  logic signed [15:0] a_pipe [2];
  always @(posedge clk) begin a_pipe[0] <= mem[a_caddr]; a_pipe[1] <= a_pipe[0]; end
  assign a_q = a_pipe[1];
  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(2), .STRIDE(2), .BRAM_LAT(2)) u_a (
    .clk(clk), .reset(reset), .start(start && sel == 0), .mode(mode),
    .conv_addr(a_caddr), .conv_en(a_cen), .conv_q(a_q), .pool_addr(a_paddr),
    .pool_en(a_pen), .pool_we(a_pwe), .pool_d(a_pd), .busy(a_busy), .done(a_done));

  // B: CH=1 IN=3 K=2 S=1 LAT=2 (overlapping windows)
  logic [3:0] b_caddr; logic b_cen; logic signed [15:0] b_q, b_pd;
  logic [1:0] b_paddr; logic b_pen, b_pwe, b_busy, b_done;
  logic signed [15:0] b_pipe [2];
  always @(posedge clk) begin b_pipe[0] <= mem[b_caddr]; b_pipe[1] <= b_pipe[0]; end
  assign b_q = b_pipe[1];
  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(3), .POOL(2), .STRIDE(1), .BRAM_LAT(2)) u_b (
    .clk(clk), .reset(reset), .start(start && sel == 1), .mode(mode),
    .conv_addr(b_caddr), .conv_en(b_cen), .conv_q(b_q), .pool_addr(b_paddr),
    .pool_en(b_pen), .pool_we(b_pwe), .pool_d(b_pd), .busy(b_busy), .done(b_done));

  // C: CH=2 IN=4 K=2 S=2 LAT=1
  logic [4:0] c_caddr; logic c_cen; logic signed [15:0] c_q, c_pd;
  logic [2:0] c_paddr; logic c_pen, c_pwe, c_busy, c_done;
  logic signed [15:0] c_pipe0;
  always @(posedge clk) c_pipe0 <= mem[c_caddr];
  assign c_q = c_pipe0;
  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(2), .BRAM_LAT(1)) u_c (
    .clk(clk), .reset(reset), .start(start && sel == 2), .mode(mode),
    .conv_addr(c_caddr), .conv_en(c_cen), .conv_q(c_q), .pool_addr(c_paddr),
    .pool_en(c_pen), .pool_we(c_pwe), .pool_d(c_pd), .busy(c_busy), .done(c_done));

  // D: CH=2 IN=4 K=2 S=2 LAT=3
  logic [4:0] d_caddr; logic d_cen; logic signed [15:0] d_q, d_pd;
  logic [2:0] d_paddr; logic d_pen, d_pwe, d_busy, d_done;
  logic signed [15:0] d_pipe [3];
  always @(posedge clk) begin
    d_pipe[0] <= mem[d_caddr]; d_pipe[1] <= d_pipe[0]; d_pipe[2] <= d_pipe[1];
  end
  assign d_q = d_pipe[2];
  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(2), .BRAM_LAT(3)) u_d (
    .clk(clk), .reset(reset), .start(start && sel == 3), .mode(mode),
    .conv_addr(d_caddr), .conv_en(d_cen), .conv_q(d_q), .pool_addr(d_paddr),
    .pool_en(d_pen), .pool_we(d_pwe), .pool_d(d_pd), .busy(d_busy), .done(d_done));

  int m_caddr, m_paddr;
  logic m_cen, m_pen, m_pwe, m_busy, m_done;
  logic signed [15:0] m_pd;
  always_comb begin
    m_caddr = 0; m_paddr = 0; m_cen = 1'b0; m_pen = 1'b0; m_pwe = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_pd = '0;
    case (sel)
      0: begin m_caddr = int'(a_caddr); m_paddr = int'(a_paddr); m_cen = a_cen; m_pen = a_pen;
               m_pwe = a_pwe; m_busy = a_busy; m_done = a_done; m_pd = a_pd; end
      1: begin m_caddr = int'(b_caddr); m_paddr = int'(b_paddr); m_cen = b_cen; m_pen = b_pen;
               m_pwe = b_pwe; m_busy = b_busy; m_done = b_done; m_pd = b_pd; end
      2: begin m_caddr = int'(c_caddr); m_paddr = int'(c_paddr); m_cen = c_cen; m_pen = c_pen;
               m_pwe = c_pwe; m_busy = c_busy; m_done = c_done; m_pd = c_pd; end
      default: begin m_caddr = int'(d_caddr); m_paddr = int'(d_paddr); m_cen = d_cen; m_pen = d_pen;
               m_pwe = d_pwe; m_busy = d_busy; m_done = d_done; m_pd = d_pd; end
    endcase
  end

  function automatic int outs_or();
    return m_caddr | m_paddr | int'(m_pd) | int'(m_cen) | int'(m_pen) | int'(m_pwe)
         | int'(m_busy) | int'(m_done);
  endfunction

  // Run one job on instance s. Cycle 0 is the cycle start is sampled in;
  // window k's write lands in cycle (k+1)*period and done in nwin*period+1.
  // pulse_at > 0 re-pulses start and flips mode in that cycle.
  task automatic run(input string nm, input int s, input logic md, input int period,
                     input int nwin, input int pulse_at);
    int wa [8]; int wd [8]; int wc [8];
    int nw, nen, nbad, done_at;
    logic got;
    sel = s; mode = md; nw = 0; nen = 0; nbad = 0; done_at = 0; got = 1'b0;
    caq.delete();
    @(negedge clk); start = 1'b1;
    for (int i = 1; i <= nwin * period + 10 && !got; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
      if (i == pulse_at) mode = ~mode;
      if (m_cen) begin nen++; caq.push_back(m_caddr); end
      if (m_pwe) begin
        if (nw < 8) begin wa[nw] = m_paddr; wd[nw] = int'(m_pd); wc[nw] = i; end
        nw++;
      end
      if (m_pen != m_pwe) nbad++;
      if (m_done) begin got = 1'b1; done_at = i; if (m_busy) nbad++; end
      else if (!m_busy) nbad++;
    end
    start = 1'b0;
    check({nm, "_done_seen"}, got, 1);
    check({nm, "_done_cycle"}, done_at, nwin * period + 1);
    check({nm, "_write_count"}, nw, nwin);
    check({nm, "_read_count"}, nen, nwin * 4);
    check({nm, "_busy_en_flags"}, nbad, 0);
    for (int k = 0; k < nwin && k < nw && k < 8; k++) begin
      check($sformatf("%s_addr%0d", nm, k), wa[k], k);
      check($sformatf("%s_data%0d", nm, k), wd[k], exp_v[k]);
      check($sformatf("%s_cycle%0d", nm, k), wc[k], (k + 1) * period);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin
      mem[i]      = 16'(i);
      mem[16 + i] = 16'(-i);
    end
  endtask

  initial begin
    int seq [16];
    int cnt;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s; #1;
      check($sformatf("reset_outputs_inst%0d", s), outs_or(), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Max over a 0..15 ramp.
    load_ramp();
    exp_v = '{5, 7, 13, 15, 0, 0, 0, 0};
    run("max_ramp", 0, 1'b0, 7, 4, 0);

    // Average rounding and saturation-free extremes, then max on the same data.
    mem[0] = -1; mem[1] = -2; mem[4] = -2; mem[5] = -2;
    mem[2] = 3;  mem[3] = 4;  mem[6] = 4;  mem[7] = 4;
    mem[8] = 32767;  mem[9] = 32767;  mem[12] = 32767;  mem[13] = 32767;
    mem[10] = -32768; mem[11] = -32768; mem[14] = -32768; mem[15] = -32768;
    exp_v = '{-2, 3, 32767, -32768, 0, 0, 0, 0};
    run("avg_edges", 0, 1'b1, 7, 4, 0);
    exp_v = '{-1, 4, 32767, -32768, 0, 0, 0, 0};
    run("max_signed", 0, 1'b0, 7, 4, 0);

    // Overlapping windows on a 3x3 map of 1..9.
    for (int i = 0; i < 9; i++) mem[i] = 16'(i + 1);
    exp_v = '{5, 6, 8, 9, 0, 0, 0, 0};
    run("overlap", 1, 1'b0, 7, 4, 0);
    seq = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
    check("overlap_addr_count", caq.size(), 16);
    for (int j = 0; j < 16 && j < caq.size(); j++)
      check($sformatf("overlap_conv_addr%0d", j), caq[j], seq[j]);

    // Two channels, channel 1 = -channel 0; latency 1 and 3.
    load_ramp();
    exp_v = '{5, 7, 13, 15, 0, -2, -8, -10};
    run("mc_lat1_toggle", 2, 1'b0, 6, 8, 10);
    run("mc_lat3_restart", 3, 1'b0, 8, 8, 20);
    exp_v = '{2, 4, 10, 12, -3, -5, -11, -13};
    run("mc_lat3_avg", 3, 1'b1, 8, 8, 0);

    // Reset during DRAIN aborts without done; a fresh run then completes.
    sel = 0; mode = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", m_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs_zero", outs_or(), 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_done || m_pwe || m_busy || m_cen) cnt++;
    end
    check("abort_no_activity", cnt, 0);
    exp_v = '{5, 7, 13, 15, 0, 0, 0, 0};
    run("after_abort", 0, 1'b0, 7, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
